acc_mem_arbiter: RTL

- Shares one single-port local SRAM of the accelerator domain between two requesters.
- Requester 1 is the RISC-V core port (en/we/addr/wdata, stall-based handshake). Requester 2 is the external NoC/DMA access port.
- Sits between the core wrapper and the SRAM. It grants one access per cycle, stalls the loser and steers read data back to the correct requester.
- Core has priority, with a bounded-starvation guarantee for the external port.

---
 rtl/acc_mem_arbiter_if.sv | 57 +++++
 rtl/acc_mem_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/acc_mem_arbiter_if.sv
// Bus bundle for acc_mem_arbiter: core port, external port, SRAM port and
// stall statistics. The arbiter uses the slave view. The environment
// (core wrapper, NoC/DMA port, SRAM) uses the master view.
interface acc_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    localparam int BE_W = DATA_W / 8;

    // Core requester
    logic              core_en_i;
    logic [BE_W-1:0]   core_we_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [DATA_W-1:0] core_wdata_i;
    logic [DATA_W-1:0] core_rdata_o;
    logic              core_stall_o;

    // External (NoC/DMA) requester
    logic              ext_en_i;
    logic [BE_W-1:0]   ext_we_i;
    logic [ADDR_W-1:0] ext_addr_i;
    logic [DATA_W-1:0] ext_wdata_i;
    logic [DATA_W-1:0] ext_rdata_o;
    logic              ext_stall_o;

    // Single-port SRAM
    logic              mem_en_o;
    logic [BE_W-1:0]   mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Stall statistics
    logic [CNT_W-1:0]  core_wait_cnt_o;
    logic [CNT_W-1:0]  ext_wait_cnt_o;

    modport slave (
        input  core_en_i, core_we_i, core_addr_i, core_wdata_i,
        output core_rdata_o, core_stall_o,
        input  ext_en_i, ext_we_i, ext_addr_i, ext_wdata_i,
        output ext_rdata_o, ext_stall_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output core_wait_cnt_o, ext_wait_cnt_o
    );

    modport master (
        output core_en_i, core_we_i, core_addr_i, core_wdata_i,
        input  core_rdata_o, core_stall_o,
        output ext_en_i, ext_we_i, ext_addr_i, ext_wdata_i,
        input  ext_rdata_o, ext_stall_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  core_wait_cnt_o, ext_wait_cnt_o
    );
endinterface

// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter: shares one single-port SRAM between the RISC-V core port
// and the external NoC/DMA port. The core has priority. The external port is
// guaranteed a grant after at most MAX_BURST consecutive core grants.
//
// Handshake: a requester raises en with stable we/addr/wdata and holds them
// until accepted. A request is accepted in any cycle where en=1 and stall=0.
// Read data appears on that requester's rdata exactly one cycle later and
// stays there until its next read returns.
module acc_mem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    acc_mem_arbiter_if.slave bus
);
    localparam int               BE_W        = DATA_W / 8;
    localparam logic [3:0]       BURST_LIMIT = 4'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    // Consecutive core grants while the external port is waiting
    logic [3:0]        streak_q, streak_d;
    // Read return pending for each requester
    logic              rd_core_q, rd_core_d;
    logic              rd_ext_q, rd_ext_d;
    // Last returned read data per requester
    logic [DATA_W-1:0] hold_core_q, hold_core_d;
    logic [DATA_W-1:0] hold_ext_q, hold_ext_d;
    // Saturating stall statistics
    logic [CNT_W-1:0]  core_cnt_q, core_cnt_d;
    logic [CNT_W-1:0]  ext_cnt_q, ext_cnt_d;

    logic              gnt_core, gnt_ext;
    logic              core_stall, ext_stall;
    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Grant: external wins only when the core is idle or has used up its burst.
    // Nothing is granted while reset is asserted.
    always_comb begin
        gnt_ext    = resetn_i & bus.ext_en_i &
                     (~bus.core_en_i | (streak_q == BURST_LIMIT));
        gnt_core   = resetn_i & bus.core_en_i & ~gnt_ext;
        core_stall = bus.core_en_i & ~gnt_core;
        ext_stall  = bus.ext_en_i & ~gnt_ext;
    end

    // SRAM request mux: fields of the granted requester, all zero when idle.
    always_comb begin
        mem_en    = gnt_core | gnt_ext;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_core) begin
            mem_we    = bus.core_we_i;
            mem_addr  = bus.core_addr_i;
            mem_wdata = bus.core_wdata_i;
        end else if (gnt_ext) begin
            mem_we    = bus.ext_we_i;
            mem_addr  = bus.ext_addr_i;
            mem_wdata = bus.ext_wdata_i;
        end
    end

    // Next-state: streak, read-return flags, data holds and counters.
    always_comb begin
        streak_d    = streak_q;
        rd_core_d   = gnt_core & (bus.core_we_i == '0);
        rd_ext_d    = gnt_ext & (bus.ext_we_i == '0);
        hold_core_d = rd_core_q ? bus.mem_rdata_i : hold_core_q;
        hold_ext_d  = rd_ext_q ? bus.mem_rdata_i : hold_ext_q;
        core_cnt_d  = core_cnt_q;
        ext_cnt_d   = ext_cnt_q;

        if (gnt_ext || !bus.ext_en_i) begin
            streak_d = 4'd0;
        end else if (gnt_core) begin
            streak_d = streak_q + 4'd1;
        end

        if (core_stall && (core_cnt_q != CNT_SAT)) begin
            core_cnt_d = core_cnt_q + 1'b1;
        end
        if (ext_stall && (ext_cnt_q != CNT_SAT)) begin
            ext_cnt_d = ext_cnt_q + 1'b1;
        end
    end

    // State registers; an asynchronous reset discards any read in flight.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            streak_q    <= 4'd0;
            rd_core_q   <= 1'b0;
            rd_ext_q    <= 1'b0;
            hold_core_q <= '0;
            hold_ext_q  <= '0;
            core_cnt_q  <= '0;
            ext_cnt_q   <= '0;
        end else begin
            streak_q    <= streak_d;
            rd_core_q   <= rd_core_d;
            rd_ext_q    <= rd_ext_d;
            hold_core_q <= hold_core_d;
            hold_ext_q  <= hold_ext_d;
            core_cnt_q  <= core_cnt_d;
            ext_cnt_q   <= ext_cnt_d;
        end
    end

    assign bus.core_stall_o    = core_stall;
    assign bus.ext_stall_o     = ext_stall;
    assign bus.mem_en_o        = mem_en;
    assign bus.mem_we_o        = mem_we;
    assign bus.mem_addr_o      = mem_addr;
    assign bus.mem_wdata_o     = mem_wdata;
    // Returning read data passes straight through; otherwise the held value.
    assign bus.core_rdata_o    = rd_core_q ? bus.mem_rdata_i : hold_core_q;
    assign bus.ext_rdata_o     = rd_ext_q ? bus.mem_rdata_i : hold_ext_q;
    assign bus.core_wait_cnt_o = core_cnt_q;
    assign bus.ext_wait_cnt_o  = ext_cnt_q;
endmodule
